// File: rtl/mem_lsu_stage_if.sv
// mem_lsu_stage_if: single-outstanding data-memory bus between the LSU stage and memory.
interface mem_lsu_stage_if #(parameter int ADDR_W = 32);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_ack;
  logic [31:0]       dm_rdata;
  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata, input dm_ack, dm_rdata);
  modport slave (input dm_req, dm_we, dm_addr, dm_be, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: load/store pipeline stage with single-outstanding bus, timeout abort and misalign flagging.
module mem_lsu_stage #(
  parameter int ADDR_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [REG_AW-1:0] wd_i,
  input  logic [31:0]       wdata_i,
  input  logic              wreg_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_sdata_i,
  mem_lsu_stage_if.master   dm,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wd_o,
  output logic [31:0]       wdata_o,
  output logic              wreg_o,
  output logic              misalign_o,
  output logic              buserr_o,
  output logic [ADDR_W-1:0] badaddr_o
);
  localparam int CW   = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = TIMEOUT > 0 ? TIMEOUT - 1 : 0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, baddr_q, baddr_d;
  logic [3:0]        be_q, be_d, op_q, op_d;
  logic [31:0]       sw_q, sw_d;
  logic [1:0]        lane_q, lane_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rwe_q, rwe_d;

  logic              wbv_q, wbv_d, wreg_q, wreg_d, mis_q, mis_d, berr_q, berr_d;
  logic [REG_AW-1:0] wd_q, wd_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [ADDR_W-1:0] bad_q, bad_d;

  logic        is_ld, is_st, is_h, is_w, mis, acc, bus_go, ack, abort;
  logic [1:0]  lane;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld, st_word;
  logic [3:0]  st_be;

  assign lane   = mem_addr_i[1:0];
  assign is_ld  = mem_op_i inside {[4'd1:4'd5]};
  assign is_st  = mem_op_i inside {4'd9, 4'd10, 4'd11};
  assign is_h   = mem_op_i inside {4'd3, 4'd4, 4'd10};
  assign is_w   = mem_op_i inside {4'd5, 4'd11};
  assign mis    = (is_h & lane[0]) | (is_w & |lane);
  assign acc    = ex_valid & ex_ready;
  assign bus_go = acc & (is_ld | is_st) & ~mis;
  assign ack    = (state_q == S_WAIT) & dm.dm_ack;
  // The ack on the final allowed cycle takes precedence over the abort.
  assign abort  = (TIMEOUT > 0) && (state_q == S_WAIT) && !dm.dm_ack && (cnt_q == CW'(TLIM));

  assign st_word = mem_op_i == 4'd9  ? {4{mem_sdata_i[7:0]}} :
                   mem_op_i == 4'd10 ? {2{mem_sdata_i[15:0]}} : mem_sdata_i;
  assign st_be   = is_ld             ? 4'b1111 :
                   mem_op_i == 4'd9  ? 4'b0001 << lane :
                   mem_op_i == 4'd10 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;

  assign lb = dm.dm_rdata[{lane_q, 3'b000} +: 8];
  assign lh = lane_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
  assign ld = op_q == 4'd1 ? {{24{lb[7]}}, lb} :
              op_q == 4'd2 ? {24'b0, lb} :
              op_q == 4'd3 ? {{16{lh[15]}}, lh} :
              op_q == 4'd4 ? {16'b0, lh} : dm.dm_rdata;

  assign ex_ready    = state_q == S_IDLE;
  assign dm.dm_req   = state_q == S_WAIT;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = sw_q;

  assign wb_valid   = wbv_q;
  assign wd_o       = wd_q;
  assign wdata_o    = wdat_q;
  assign wreg_o     = wreg_q;
  assign misalign_o = mis_q;
  assign buserr_o   = berr_q;
  assign badaddr_o  = bad_q;

  always_comb begin
    state_d = bus_go ? S_WAIT : (ack | abort) ? S_IDLE : state_q;
    cnt_d   = state_q == S_WAIT ? cnt_q + 1'b1 : '0;
    we_d    = bus_go ? is_st : we_q;
    addr_d  = bus_go ? {mem_addr_i[ADDR_W-1:2], 2'b00} : addr_q;
    baddr_d = bus_go ? mem_addr_i : baddr_q;
    be_d    = bus_go ? st_be : be_q;
    sw_d    = bus_go ? st_word : sw_q;
    op_d    = bus_go ? mem_op_i : op_q;
    lane_d  = bus_go ? lane : lane_q;
    rd_d    = bus_go ? wd_i : rd_q;
    rwe_d   = bus_go ? wreg_i : rwe_q;
  end

  always_comb begin
    wbv_d  = 1'b0;
    wd_d   = wd_q;
    wdat_d = wdat_q;
    wreg_d = wreg_q;
    mis_d  = mis_q;
    berr_d = berr_q;
    bad_d  = bad_q;
    if (acc && !(is_ld || is_st)) begin
      wbv_d  = 1'b1;
      wd_d   = wd_i;
      wdat_d = wdata_i;
      wreg_d = wreg_i;
      mis_d  = 1'b0;
      berr_d = 1'b0;
    end else if (acc && mis) begin
      wbv_d  = 1'b1;
      wd_d   = wd_i;
      wreg_d = 1'b0;
      mis_d  = 1'b1;
      berr_d = 1'b0;
      bad_d  = mem_addr_i;
    end else if (ack) begin
      wbv_d  = 1'b1;
      wd_d   = rd_q;
      wdat_d = we_q ? sw_q : ld;
      wreg_d = ~we_q & rwe_q;
      mis_d  = 1'b0;
      berr_d = 1'b0;
    end else if (abort) begin
      wbv_d  = 1'b1;
      wd_d   = rd_q;
      wreg_d = 1'b0;
      mis_d  = 1'b0;
      berr_d = 1'b1;
      bad_d  = baddr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      baddr_q <= '0;
      be_q    <= '0;
      sw_q    <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      rd_q    <= '0;
      rwe_q   <= 1'b0;
      wbv_q   <= 1'b0;
      wd_q    <= '0;
      wdat_q  <= '0;
      wreg_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      baddr_q <= baddr_d;
      be_q    <= be_d;
      sw_q    <= sw_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      rd_q    <= rd_d;
      rwe_q   <= rwe_d;
      wbv_q   <= wbv_d;
      wd_q    <= wd_d;
      wdat_q  <= wdat_d;
      wreg_q  <= wreg_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      bad_q   <= bad_d;
    end
  end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: directed checks of pass-through, loads, stores, misalign, timeout and async reset.
module tb_mem_lsu_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, wreg_i;
  logic [4:0]  wd_i, wd_o;
  logic [31:0] wdata_i, mem_addr_i, mem_sdata_i, wdata_o, badaddr_o;
  logic [3:0]  mem_op_i;
  logic        wb_valid, wreg_o, misalign_o, buserr_o;
  int          total = 0;
  int          bad = 0;

  mem_lsu_stage_if #(.ADDR_W(32)) dm ();

  mem_lsu_stage #(.ADDR_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .wd_i(wd_i), .wdata_i(wdata_i), .wreg_i(wreg_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i), .dm(dm.master),
    .wb_valid(wb_valid), .wd_o(wd_o), .wdata_o(wdata_o), .wreg_o(wreg_o),
    .misalign_o(misalign_o), .buserr_o(buserr_o), .badaddr_o(badaddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    ex_valid = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD0000;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] exp);
    issue(op, addr, 32'h0);
    chk({tag, "_req"}, 32'(dm.dm_req), 32'd1);
    chk({tag, "_rdy"}, 32'(ex_ready), 32'd0);
    chk({tag, "_be"}, 32'(dm.dm_be), 32'hF);
    chk({tag, "_we"}, 32'(dm.dm_we), 32'd0);
    chk({tag, "_addr"}, dm.dm_addr, addr & 32'hFFFF_FFFC);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h80FF7F01;
    step();
    dm.dm_ack = 1'b0;
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wdata_o, exp);
    chk({tag, "_wreg"}, 32'(wreg_o), 32'd1);
    chk({tag, "_wd"}, 32'(wd_o), 32'd7);
    chk({tag, "_rdy2"}, 32'(ex_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; wd_i = '0; wdata_i = '0; wreg_i = 1'b0;
    mem_op_i = '0; mem_addr_i = '0; mem_sdata_i = '0;
    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
    #2;
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(dm.dm_req), 32'd0);
    chk("rst_be", 32'(dm.dm_be), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_badaddr", badaddr_o, 32'd0);
    step();
    rst = 1'b1;
    step();

    for (int i = 1; i <= 4; i++) begin
      ex_valid = 1'b1; mem_op_i = 4'd0; wd_i = 5'(i); wdata_i = 32'h11 * i; wreg_i = 1'b1;
      step();
      chk("pt_wbv", 32'(wb_valid), 32'd1);
      chk("pt_wd", 32'(wd_o), 32'(i));
      chk("pt_wdata", wdata_o, 32'h11 * i);
      chk("pt_wreg", 32'(wreg_o), 32'd1);
      chk("pt_rdy", 32'(ex_ready), 32'd1);
    end
    ex_valid = 1'b0;
    step();
    chk("pt_idle_wbv", 32'(wb_valid), 32'd0);
    chk("pt_hold_wd", 32'(wd_o), 32'd4);

    do_load("lb3", 4'd1, 32'h0000_0043, 32'hFFFFFF80);
    do_load("lbu3", 4'd2, 32'h0000_0043, 32'h00000080);
    do_load("lh2", 4'd3, 32'h0000_0042, 32'hFFFF80FF);
    do_load("lhu0", 4'd4, 32'h0000_0040, 32'h00007F01);
    do_load("lw", 4'd5, 32'h0000_0044, 32'h80FF7F01);

    issue(4'd9, 32'h103, 32'h0000_00AB);
    chk("sb_addr", dm.dm_addr, 32'h100);
    chk("sb_be", 32'(dm.dm_be), 32'b1000);
    chk("sb_wdata", dm.dm_wdata, 32'hABABABAB);
    chk("sb_we", 32'(dm.dm_we), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("sb_wait_rdy", 32'(ex_ready), 32'd0);
      chk("sb_wait_wbv", 32'(wb_valid), 32'd0);
      step();
    end
    chk("sb_last_rdy", 32'(ex_ready), 32'd0);
    chk("sb_stable_be", 32'(dm.dm_be), 32'b1000);
    dm.dm_ack = 1'b1;
    step();
    dm.dm_ack = 1'b0;
    chk("sb_wbv", 32'(wb_valid), 32'd1);
    chk("sb_wreg", 32'(wreg_o), 32'd0);
    chk("sb_berr", 32'(buserr_o), 32'd0);
    chk("sb_word", wdata_o, 32'hABABABAB);
    chk("sb_rdy", 32'(ex_ready), 32'd1);

    issue(4'd10, 32'h102, 32'h1234_BEEF);
    chk("sh_be", 32'(dm.dm_be), 32'b1100);
    chk("sh_wdata", dm.dm_wdata, 32'hBEEFBEEF);
    dm.dm_ack = 1'b1;
    step();
    dm.dm_ack = 1'b0;
    chk("sh_wbv", 32'(wb_valid), 32'd1);
    chk("sh_wreg", 32'(wreg_o), 32'd0);

    issue(4'd5, 32'h102, 32'h0);
    chk("mis_req", 32'(dm.dm_req), 32'd0);
    chk("mis_wbv", 32'(wb_valid), 32'd1);
    chk("mis_flag", 32'(misalign_o), 32'd1);
    chk("mis_bad", badaddr_o, 32'h102);
    chk("mis_wreg", 32'(wreg_o), 32'd0);
    chk("mis_rdy", 32'(ex_ready), 32'd1);
    issue(4'd3, 32'h201, 32'h0);
    chk("mis_lh_flag", 32'(misalign_o), 32'd1);
    chk("mis_lh_bad", badaddr_o, 32'h201);
    issue(4'd9, 32'h201, 32'h0);
    chk("sb_odd_ok_req", 32'(dm.dm_req), 32'd1);
    chk("sb_odd_ok_be", 32'(dm.dm_be), 32'b0010);
    dm.dm_ack = 1'b1;
    step();
    dm.dm_ack = 1'b0;
    chk("sb_odd_mis", 32'(misalign_o), 32'd0);

    issue(4'd5, 32'h200, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(dm.dm_req), 32'd1);
      chk("to_wbv", 32'(wb_valid), 32'd0);
      step();
    end
    chk("to_req_drop", 32'(dm.dm_req), 32'd0);
    chk("to_wbv_pulse", 32'(wb_valid), 32'd1);
    chk("to_berr", 32'(buserr_o), 32'd1);
    chk("to_bad", badaddr_o, 32'h200);
    chk("to_wreg", 32'(wreg_o), 32'd0);
    chk("to_mis", 32'(misalign_o), 32'd0);

    issue(4'd5, 32'h204, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("to4_req", 32'(dm.dm_req), 32'd1);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h12345678;
    step();
    dm.dm_ack = 1'b0;
    chk("to4_wbv", 32'(wb_valid), 32'd1);
    chk("to4_berr", 32'(buserr_o), 32'd0);
    chk("to4_data", wdata_o, 32'h12345678);
    chk("to4_wreg", 32'(wreg_o), 32'd1);

    issue(4'd5, 32'h300, 32'h0);
    step();
    chk("rw_req_pre", 32'(dm.dm_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("rw_req_async", 32'(dm.dm_req), 32'd0);
    chk("rw_rdy_async", 32'(ex_ready), 32'd1);
    step();
    rst = 1'b1;
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hCAFEF00D;
    step();
    dm.dm_ack = 1'b0;
    chk("rw_no_wbv", 32'(wb_valid), 32'd0);
    chk("rw_rdy", 32'(ex_ready), 32'd1);
    chk("rw_req", 32'(dm.dm_req), 32'd0);
    chk("rw_wdata_clr", wdata_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu_stage.md
# mem_lsu_stage

Parametrised memory-access pipeline stage, the successor to the pass-through MEM stage. It sits between EX/MEM and MEM/WB. It accepts one instruction per handshake from EX and executes byte/halfword/word loads and stores on a single-outstanding data-memory bus with req/ack. It stalls EX while a bus access is in flight, aborts accesses that time out, flags misaligned addresses, and delivers a registered result to WB.

## Interface
Parameters:
- ADDR_W, 32, data-memory byte-address width (≥ 3)
- REG_AW, 5, destination register index width
- TIMEOUT, 16, max cycles dm_req is held without dm_ack before abort; 0 = never abort

Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage accepts; transfer on ex_valid & ex_ready at rising edge
- wd_i  in  REG_AW  destination register
- wdata_i  in  32  ALU result (non-memory ops)
- wreg_i  in  1  register write enable
- mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; any other code = NONE
- mem_addr_i  in  ADDR_W  byte address
- mem_sdata_i  in  32  store data
- dm_req  out  1  bus request
- dm_we  out  1  1 = write
- dm_addr  out  ADDR_W  word-aligned address, addr[1:0] = 0
- dm_be  out  4  byte enables, bit i = lane i
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  access complete; dm_rdata valid this cycle
- dm_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse per retired instruction
- wd_o  out  REG_AW  destination register
- wdata_o  out  32  result
- wreg_o  out  1  register write enable
- misalign_o  out  1  qualified by wb_valid
- buserr_o  out  1  timeout abort, qualified by wb_valid
- badaddr_o  out  ADDR_W  faulting byte address, valid with misalign_o or buserr_o

## Operation
- FSM has two states. IDLE: ex_ready = 1, dm_req = 0. WAIT: ex_ready = 0, dm_req = 1.
- All WB-side outputs are registered. On any edge with no retirement, wb_valid = 0 and the other WB-side outputs hold their value.
- Accept of NONE: the next edge retires it with wd_o = wd_i, wdata_o = wdata_i, wreg_o = wreg_i. The FSM stays in IDLE.
- Misalignment rules:
  - LH/LHU/SH is misaligned if addr[0] = 1.
  - LW/SW is misaligned if addr[1:0] ≠ 0.
  - A misaligned access never requests the bus. The next edge retires it with wreg_o = 0, misalign_o = 1, badaddr_o = addr.
- Accept of an aligned load or store: the FSM enters WAIT.
  - The stage latches dm_addr, dm_we, dm_be, dm_wdata, op, lane, wd and wreg.
  - These bus outputs stay stable for the whole of WAIT.
- Store lanes (little-endian, lane = addr[1:0]):
  - SB: dm_be = 1 << lane; dm_wdata = {4{sdata[7:0]}}
  - SH: dm_be = 0011 or 1100; dm_wdata = {2{sdata[15:0]}}
  - SW: dm_be = 1111; dm_wdata = sdata
- Loads drive dm_be = 1111 and dm_we = 0.
- Load extraction selects byte/half by lane:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Retirement on dm_ack in WAIT. The FSM returns to IDLE.
  - Loads: wdata_o = extracted data, wreg_o = latched wreg.
  - Stores: wreg_o = 0, wdata_o = store word.
  - misalign_o = 0 and buserr_o = 0.
- Timeout (TIMEOUT > 0): a counter clears on entering WAIT and increments on each WAIT cycle without ack.
  - If the cycle with count = TIMEOUT−1 has no ack, that edge aborts the access.
  - Abort retires with wreg_o = 0, buserr_o = 1, badaddr_o = original byte address, and returns the FSM to IDLE.
  - An ack on that final cycle wins and retires normally.
- dm_ack in IDLE is ignored.
- Reset:
  - Asserting rst immediately forces IDLE.
  - dm_req, dm_we, dm_be, wb_valid, wreg_o, misalign_o and buserr_o go to 0.
  - dm_addr, dm_wdata, wd_o, wdata_o and badaddr_o go to 0.
  - The counter goes to 0.
  - An in-flight access is dropped with no retirement.
  - After deassertion the stage is in IDLE with ex_ready = 1.

## Timing
- NONE or misaligned: accept at edge E, wb_valid high for the cycle after E. Throughput is 1 per cycle.
- Bus op: accept at E0 and dm_req rises after E0.
  - With ack in the first WAIT cycle, wb_valid is high after E1 and the next accept is possible at E2.
  - Throughput is therefore 1 per (2 + wait states) cycles.
- ex_ready is low exactly while in WAIT; it is a function of state only.
- Maximum dm_req duration is TIMEOUT cycles.

## Test plan
- Pass-through: 4 back-to-back NONE ops with wd = 1..4 and wdata = 0x11..0x44 -> four consecutive wb_valid pulses with matching wd_o/wdata_o/wreg_o. ex_ready stays 1.
- Loads, zero wait, dm_rdata = 0x80FF7F01:
  - LB at lane 3 -> 0xFFFFFF80
  - LBU at lane 3 -> 0x00000080
  - LH at lane 2 -> 0xFFFF80FF
  - LHU at lane 0 -> 0x00007F01
  - LW -> 0x80FF7F01
  - Each retires 2 cycles after accept.
- Stores: SB addr 0x103, sdata 0xAB -> dm_addr 0x100, dm_be 1000, dm_wdata 0xABABABAB. SH addr 0x102 -> dm_be 1100. Ack after 3 wait cycles -> ex_ready low for 4 cycles; wb_valid with wreg_o = 0.
- Misalign: LW at 0x102 -> no dm_req; wb_valid next cycle with misalign_o = 1, badaddr_o = 0x102, wreg_o = 0.
- Timeout with TIMEOUT = 4, no ack -> dm_req high exactly 4 cycles, then buserr_o = 1 with wb_valid. A repeat with ack on the 4th cycle -> normal retirement, buserr_o = 0.
- Reset mid-WAIT: assert rst two cycles into a load -> dm_req drops without waiting for a clock edge, no wb_valid, ex_ready = 1 after release. A late dm_ack is ignored.
